alu_mul_unit: RTL and testbench
===============================

Name: alu_mul_unit

Overview:
- Parametrised successor to the CPU's single-cycle ALU: an execute unit for all 16 ARM data-processing ops, plus iterative MUL/MLA/UMULL/UMLAL/SMULL/SMLAL.
- Multiplies use ARM7-style early termination, processing STEP multiplier bits per cycle.
- Sits in the execute stage after the barrel shifter. A valid/ready handshake on the input side lets the control FSM stall for multi-cycle multiplies.

Parameters:
- WIDTH, 32, operand width. Long-multiply result is 2*WIDTH.
- STEP, 8, multiplier bits consumed per iteration. Must divide WIDTH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request
- op  in  5  op[4]=0: data op, op[3:0] = ARM opcode (AND,EOR,SUB,RSB,ADD,ADC,SBC,RSC,TST,TEQ,CMP,CMN,ORR,MOV,BIC,MVN). op[4]=1: 0 MUL, 1 MLA, 4 UMULL, 5 UMLAL, 6 SMULL, 7 SMLAL.
- op_a  in  WIDTH  Rn (data op) / Rm multiplicand
- op_b  in  WIDTH  shifter output (data op) / Rs multiplier
- acc_lo  in  WIDTH  accumulator low (MLA: Rn; long: RdLo)
- acc_hi  in  WIDTH  accumulator high (long accumulate: RdHi)
- shifter_carry  in  1  shifter carry-out
- flags_in  in  4  {N,Z,C,V} current CPSR flags
- out_valid  out  1  single-cycle result strobe
- result_lo  out  WIDTH  result / product low half
- result_hi  out  WIDTH  product high half (0 for non-long ops)
- flags_out  out  4  {N,Z,C,V}
- mul_cycles  out  4  iteration count of the last multiply (0 for data ops)

Behaviour:
- Reset (synchronous, active-high): FSM to IDLE. in_ready=1, out_valid=0. result_lo, result_hi, mul_cycles = 0. flags_out=0.
- Reset mid-multiply aborts the operation with no out_valid. Reset has priority over in_valid.
- Accept: in_valid & in_ready at a rising edge. All inputs are captured at accept and are don't-care afterwards.
- FSM states: IDLE, MUL, ACC.
  - IDLE: data op → stays IDLE; results registered at the accepting edge.
  - IDLE: multiply → MUL.
  - MUL, after m iterations: → ACC if accumulating, else → IDLE.
  - ACC: one cycle → IDLE.
- in_ready = (state==IDLE). in_valid is ignored while busy.
- out_valid is high for exactly one cycle, L cycles after the accept cycle.
  - Data ops: L=1.
  - Multiplies: L = m + a, where a=1 for MLA/UMLAL/SMLAL and a=0 otherwise.
  - in_ready is high in the out_valid cycle, so back-to-back accept is allowed.
- Outputs hold their values until the next out_valid.
- Early termination, m in 1..WIDTH/STEP: m is the smallest k such that op_b[WIDTH-1:k*STEP] is all zeros.
  - For MUL, MLA, SMULL and SMLAL, all ones also terminates.
  - For UMULL and UMLAL, only all zeros terminates.
  - m = WIDTH/STEP if no k qualifies. mul_cycles = m.
- Product must equal the exact mathematical result regardless of m. Signed ops treat both operands as two's complement.
- MUL/MLA:
  - result_lo = (op_a*op_b [+acc_lo]) mod 2^WIDTH; result_hi=0.
  - N = result_lo MSB; Z = (result_lo==0).
- Long ops: {result_hi,result_lo} = op_a*op_b [+ {acc_hi,acc_lo}] mod 2^(2*WIDTH).
  - N = result_hi MSB; Z = (all 2*WIDTH bits == 0).
- Multiplies: C = flags_in.C, V = flags_in.V.
- Data ops, result in WIDTH bits:
  - Logical ops (AND,EOR,TST,TEQ,ORR,MOV,BIC,MVN): C = shifter_carry; V unchanged.
  - Arithmetic ops: computed in WIDTH+1 bits.
  - Add-type: C = carry-out.
  - Subtract-type (SUB,RSB,SBC,RSC,CMP): C = NOT borrow.
  - ADC: adds flags_in.C. SBC/RSC: subtract ~flags_in.C.
  - V = signed overflow of the effective operand order (RSB/RSC use op_b − op_a).
  - N = result MSB; Z = (result==0).
- TST/TEQ/CMP/CMN: result_lo is driven with the computed value; writeback suppression is the decoder's concern.
- Data op result_hi = 0.

Test Plan:
- ADD, op_a=0x7FFFFFFF, op_b=1 → next cycle: out_valid=1, result_lo=0x80000000, flags N1 Z0 C0 V1, mul_cycles=0.
- SUB 5−5 → result 0, Z1 C1 N0 V0. Then RSC with op_a=1, op_b=0, flags_in.C=0 → 0xFFFFFFFE, C0, N1.
- MUL, op_a=7, op_b=0x12 → m=1; out_valid 1 cycle after accept; result 0x7E. Repeat with op_b=0x01000000 → m=4, out_valid after 4 cycles, result 0x07000000.
- SMULL, op_a=3, op_b=0xFFFFFF80 → m=1; {hi,lo}=0xFFFFFFFF_FFFFFE80; N1. UMULL with the same operands → m=4; 0x00000002_FFFFFE80; N0; C/V equal flags_in.
- MLA 2*3+4 → out_valid 2 cycles after accept, result 10. Hold in_valid high with an ADD throughout → ADD accepted only in the out_valid cycle; its result appears 1 cycle later.
- UMULL with op_b=0x80000000 started, then reset asserted at iteration 2 → no out_valid, in_ready=1 and outputs 0 next cycle; a subsequent ADD completes normally.

Source files
------------

// File: rtl/alu_mul_unit.sv
// Execute unit: 16 ARM data-processing ops (1-cycle) and iterative MUL/MLA/xMULL/xMLAL, STEP multiplier bits/cycle.
// Latency 1 for data ops, m(+1 when accumulating) for multiplies; in_ready low while a multiply is in flight.
module alu_mul_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic             shifter_carry,
  input  logic [3:0]       flags_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags_out,
  output logic [3:0]       mul_cycles
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC} state_t;

  state_t            state_q, state_d;
  logic [W2-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [W2-1:0]     prod_q, prod_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [CW-1:0]     rem_q, rem_d;
  logic [CW-1:0]     m_q, m_d;
  logic              long_q, long_d;
  logic              acc_en_q, acc_en_d;
  logic              neg_q, neg_d;
  logic [1:0]        cv_q, cv_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  result_lo_q, result_lo_d;
  logic [WIDTH-1:0]  result_hi_q, result_hi_d;
  logic [3:0]        flags_q, flags_d;
  logic [3:0]        mul_cycles_q, mul_cycles_d;

  logic              idle;
  logic              unused_flags_nz;

  assign idle            = (state_q == S_IDLE);
  assign in_ready        = idle;
  assign unused_flags_nz = ^flags_in[3:2];

  assign out_valid  = out_valid_q;
  assign result_lo  = result_lo_q;
  assign result_hi  = result_hi_q;
  assign flags_out  = flags_q;
  assign mul_cycles = mul_cycles_q;

  // ---------------- data-processing ALU ----------------
  logic [WIDTH-1:0]  x_op, y_op, logic_res, alu_res;
  logic [WIDTH:0]    sum;
  logic              cin, arith, alu_c, alu_v;

  always_comb begin
    x_op      = op_a;
    y_op      = op_b;
    cin       = 1'b0;
    arith     = 1'b1;
    logic_res = '0;
    case (op[3:0])
      4'h0, 4'h8: begin arith = 1'b0; logic_res = op_a & op_b;  end
      4'h1, 4'h9: begin arith = 1'b0; logic_res = op_a ^ op_b;  end
      4'hC:       begin arith = 1'b0; logic_res = op_a | op_b;  end
      4'hD:       begin arith = 1'b0; logic_res = op_b;         end
      4'hE:       begin arith = 1'b0; logic_res = op_a & ~op_b; end
      4'hF:       begin arith = 1'b0; logic_res = ~op_b;        end
      4'h2, 4'hA: begin y_op = ~op_b; cin = 1'b1; end
      4'h3:       begin x_op = op_b; y_op = ~op_a; cin = 1'b1; end
      4'h5:       cin = flags_in[1];
      4'h6:       begin y_op = ~op_b; cin = flags_in[1]; end
      4'h7:       begin x_op = op_b; y_op = ~op_a; cin = flags_in[1]; end
      default:    begin end
    endcase
    // Subtracts run as x + ~y + cin, so the carry-out is already NOT borrow.
    sum     = {1'b0, x_op} + {1'b0, y_op} + {{WIDTH{1'b0}}, cin};
    alu_res = arith ? sum[WIDTH-1:0] : logic_res;
    alu_c   = arith ? sum[WIDTH] : shifter_carry;
    alu_v   = arith ? ((x_op[WIDTH-1] == y_op[WIDTH-1]) && (sum[WIDTH-1] != x_op[WIDTH-1]))
                    : flags_in[0];
  end

  // ---------------- early-termination count ----------------
  logic              term_ones_in;
  logic [CW-1:0]     m_calc;

  assign term_ones_in = !op[2] || op[1];

  always_comb begin
    m_calc = CW'(N);
    for (int k = N - 1; k >= 1; k--) begin
      if (((op_b >> (k * STEP)) == '0) || (term_ones_in && (((~op_b) >> (k * STEP)) == '0)))
        m_calc = CW'(k);
    end
  end

  // ---------------- shared multiply iteration ----------------
  // The first iteration runs on the live inputs during the accept cycle.
  logic [W2-1:0]     mcand_cur, mcand_nxt, partial, prod_cur, prod_step, fin_res;
  logic [WIDTH-1:0]  mplier_cur;
  logic [CW-1:0]     rem_cur, m_cur;
  logic              neg_cur, long_cur, last, fin_n, fin_z;
  logic [1:0]        cv_cur;

  always_comb begin
    if (idle) begin
      mcand_cur = (op[2] && op[1]) ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
      mplier_cur = op_b;
      prod_cur   = '0;
      rem_cur    = m_calc;
      m_cur      = m_calc;
      neg_cur    = term_ones_in && op_b[WIDTH-1];
      long_cur   = op[2];
      cv_cur     = flags_in[1:0];
    end else begin
      mcand_cur  = mcand_q;
      mplier_cur = mplier_q;
      prod_cur   = prod_q;
      rem_cur    = rem_q;
      m_cur      = m_q;
      neg_cur    = neg_q;
      long_cur   = long_q;
      cv_cur     = cv_q;
    end
    last      = (rem_cur == CW'(1));
    partial   = mcand_cur * W2'(mplier_cur[STEP-1:0]);
    mcand_nxt = mcand_cur << STEP;
    // Digits were summed as unsigned; a negative multiplier's sign weight is -2^(m*STEP).
    prod_step = prod_cur + partial - ((last && neg_cur) ? mcand_nxt : '0);
    fin_res   = (state_q == S_ACC) ? (prod_q + acc_q) : prod_step;
    fin_n     = long_cur ? fin_res[W2-1] : fin_res[WIDTH-1];
    fin_z     = long_cur ? (fin_res == '0) : (fin_res[WIDTH-1:0] == '0);
  end

  // ---------------- FSM next state / outputs ----------------
  logic step, fin;

  always_comb begin
    state_d      = state_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    prod_d       = prod_q;
    acc_d        = acc_q;
    rem_d        = rem_q;
    m_d          = m_q;
    long_d       = long_q;
    acc_en_d     = acc_en_q;
    neg_d        = neg_q;
    cv_d         = cv_q;
    out_valid_d  = 1'b0;
    result_lo_d  = result_lo_q;
    result_hi_d  = result_hi_q;
    flags_d      = flags_q;
    mul_cycles_d = mul_cycles_q;
    step         = 1'b0;
    fin          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (op[4]) begin
            step     = 1'b1;
            long_d   = op[2];
            acc_en_d = op[0];
            m_d      = m_calc;
            neg_d    = neg_cur;
            cv_d     = flags_in[1:0];
            acc_d    = {(op[2] ? acc_hi : {WIDTH{1'b0}}), acc_lo};
            if (!last)      state_d = S_MUL;
            else if (op[0]) state_d = S_ACC;
            else            fin = 1'b1;
          end else begin
            out_valid_d  = 1'b1;
            result_lo_d  = alu_res;
            result_hi_d  = '0;
            flags_d      = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
            mul_cycles_d = '0;
          end
        end
      end
      S_MUL: begin
        step = 1'b1;
        if (last) begin
          if (acc_en_q) begin
            state_d = S_ACC;
          end else begin
            state_d = S_IDLE;
            fin     = 1'b1;
          end
        end
      end
      S_ACC: begin
        state_d = S_IDLE;
        fin     = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (step) begin
      mcand_d  = mcand_nxt;
      mplier_d = mplier_cur >> STEP;
      prod_d   = prod_step;
      rem_d    = rem_cur - CW'(1);
    end
    if (fin) begin
      out_valid_d  = 1'b1;
      result_lo_d  = fin_res[WIDTH-1:0];
      result_hi_d  = long_cur ? fin_res[W2-1:WIDTH] : '0;
      flags_d      = {fin_n, fin_z, cv_cur};
      mul_cycles_d = 4'(m_cur);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mcand_q      <= '0;
      mplier_q     <= '0;
      prod_q       <= '0;
      acc_q        <= '0;
      rem_q        <= '0;
      m_q          <= '0;
      long_q       <= 1'b0;
      acc_en_q     <= 1'b0;
      neg_q        <= 1'b0;
      cv_q         <= '0;
      out_valid_q  <= 1'b0;
      result_lo_q  <= '0;
      result_hi_q  <= '0;
      flags_q      <= '0;
      mul_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      prod_q       <= prod_d;
      acc_q        <= acc_d;
      rem_q        <= rem_d;
      m_q          <= m_d;
      long_q       <= long_d;
      acc_en_q     <= acc_en_d;
      neg_q        <= neg_d;
      cv_q         <= cv_d;
      out_valid_q  <= out_valid_d;
      result_lo_q  <= result_lo_d;
      result_hi_q  <= result_hi_d;
      flags_q      <= flags_d;
      mul_cycles_q <= mul_cycles_d;
    end
  end

endmodule

// File: tb/tb_alu_mul_unit.sv
// Randomized bench for alu_mul_unit against an arithmetic reference model (WIDTH=32, STEP=8).
module tb_alu_mul_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic [31:0] op_a, op_b, acc_lo, acc_hi;
  logic        shifter_carry;
  logic [3:0]  flags_in;
  logic        out_valid;
  logic [31:0] result_lo, result_hi;
  logic [3:0]  flags_out;
  logic [3:0]  mul_cycles;

  int n_vec = 0;
  int n_mis = 0;

  logic [31:0] obs_lo, obs_hi;
  logic [3:0]  obs_fl, obs_mc;

  alu_mul_unit #(.WIDTH(32), .STEP(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .op_a(op_a), .op_b(op_b), .acc_lo(acc_lo), .acc_hi(acc_hi),
    .shifter_carry(shifter_carry), .flags_in(flags_in),
    .out_valid(out_valid), .result_lo(result_lo), .result_hi(result_hi),
    .flags_out(flags_out), .mul_cycles(mul_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint sx(input logic [31:0] x);
    return longint'($signed(x));
  endfunction

  // Reference: plain integer arithmetic on the architectural definition.
  task automatic model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] al, input logic [31:0] ah, input logic sc,
                       input logic [3:0] fi, output logic [31:0] lo, output logic [31:0] hi,
                       output logic [3:0] fl, output int m, output int lat);
    logic [63:0] full;
    longint      sr;
    longint      lim;
    logic [31:0] x, y, top, ones;
    logic        c, v, extra, acc, sgn_term;
    int          kind;
    lim = 64'sh8000_0000;
    c = sc; v = fi[0]; hi = '0; lo = '0; m = 0; lat = 1;
    x = a; y = b; extra = 1'b0; kind = 0; full = '0; sr = 0;
    if (!o[4]) begin
      case (o[3:0])
        4'h0, 4'h8: lo = a & b;
        4'h1, 4'h9: lo = a ^ b;
        4'hC:       lo = a | b;
        4'hD:       lo = b;
        4'hE:       lo = a & ~b;
        4'hF:       lo = ~b;
        4'h4, 4'hB: kind = 1;
        4'h5:       begin kind = 1; extra = fi[1]; end
        4'h2, 4'hA: kind = 2;
        4'h3:       begin kind = 2; x = b; y = a; end
        4'h6:       begin kind = 2; extra = !fi[1]; end
        4'h7:       begin kind = 2; x = b; y = a; extra = !fi[1]; end
        default:    begin end
      endcase
      if (kind == 1) begin
        full = {32'b0, x} + {32'b0, y} + 64'(extra);
        lo = full[31:0];
        c  = full[32];
        sr = sx(x) + sx(y) + longint'(extra);
        v  = (sr >= lim) || (sr < -lim);
      end else if (kind == 2) begin
        lo = x - y - 32'(extra);
        c  = ({32'b0, x} >= ({32'b0, y} + 64'(extra)));
        sr = sx(x) - sx(y) - longint'(extra);
        v  = (sr >= lim) || (sr < -lim);
      end
      fl = {lo[31], (lo == 32'h0), c, v};
    end else begin
      acc = o[0];
      sgn_term = !o[2] || o[1];
      m = 4;
      for (int k = 3; k >= 1; k--) begin
        top  = b >> (8 * k);
        ones = 32'hFFFF_FFFF;
        ones = ones >> (8 * k);
        if (top == 32'h0 || (sgn_term && top == ones)) m = k;
      end
      lat = m + int'(acc);
      if (!o[2]) begin
        full = {32'b0, a} * {32'b0, b};
        lo = full[31:0] + (acc ? al : 32'h0);
        fl = {lo[31], (lo == 32'h0), fi[1:0]};
      end else begin
        if (o[1]) full = 64'(sx(a) * sx(b));
        else      full = {32'b0, a} * {32'b0, b};
        if (acc) full = full + {ah, al};
        lo = full[31:0];
        hi = full[63:32];
        fl = {full[63], (full == 64'h0), fi[1:0]};
      end
    end
  endtask

  task automatic scramble();
    op = 5'($urandom); op_a = $urandom; op_b = $urandom;
    acc_lo = $urandom; acc_hi = $urandom;
    shifter_carry = 1'($urandom); flags_in = 4'($urandom);
  endtask

  task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] al, input logic [31:0] ah, input logic sc,
                        input logic [3:0] fi);
    logic [31:0] elo, ehi;
    logic [3:0]  efl;
    int          em, elat, lat;
    model(o, a, b, al, ah, sc, fi, elo, ehi, efl, em, elat);
    @(negedge clk);
    check("rdy_idle", 64'(in_ready), 64'(1'b1));
    in_valid = 1'b1; op = o; op_a = a; op_b = b; acc_lo = al; acc_hi = ah;
    shifter_carry = sc; flags_in = fi;
    @(negedge clk);
    in_valid = 1'b0;
    scramble();
    lat = 1;
    while (!out_valid && lat < 40) begin
      check("rdy_busy", 64'(in_ready), 64'(1'b0));
      @(negedge clk);
      lat++;
    end
    check("vld_seen", 64'(out_valid), 64'(1'b1));
    check("latency", 64'(lat), 64'(elat));
    check("res_lo", 64'(result_lo), 64'(elo));
    check("res_hi", 64'(result_hi), 64'(ehi));
    check("flags", 64'(flags_out), 64'(efl));
    check("mul_cyc", 64'(mul_cycles), 64'(em));
    check("rdy_done", 64'(in_ready), 64'(1'b1));
    obs_lo = result_lo; obs_hi = result_hi; obs_fl = flags_out; obs_mc = mul_cycles;
    @(negedge clk);
    check("vld_pulse", 64'(out_valid), 64'(1'b0));
    check("hold_lo", 64'(result_lo), 64'(elo));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] elo, ehi, a, b;
    logic [3:0]  efl;
    logic [4:0]  o;
    int          em, elat;
    bit          seen;
    logic [4:0]  mul_ops [6];
    mul_ops = '{5'h10, 5'h11, 5'h14, 5'h15, 5'h16, 5'h17};

    reset = 1'b1; in_valid = 1'b0;
    op = '0; op_a = '0; op_b = '0; acc_lo = '0; acc_hi = '0; shifter_carry = 1'b0; flags_in = '0;
    repeat (3) @(negedge clk);
    check("rst_rdy", 64'(in_ready), 64'(1'b1));
    check("rst_vld", 64'(out_valid), 64'(1'b0));
    check("rst_lo", 64'(result_lo), 64'h0);
    check("rst_hi", 64'(result_hi), 64'h0);
    check("rst_fl", 64'(flags_out), 64'h0);
    check("rst_mc", 64'(mul_cycles), 64'h0);
    reset = 1'b0;

    // Directed points with hand-derived constants
    run_op(5'h04, 32'h7FFF_FFFF, 32'h1, 0, 0, 1'b0, 4'h0);
    check("add_lo", 64'(obs_lo), 64'h8000_0000);
    check("add_fl", 64'(obs_fl), 64'b1001);
    check("add_mc", 64'(obs_mc), 64'h0);
    run_op(5'h02, 32'h5, 32'h5, 0, 0, 1'b0, 4'h0);
    check("sub_lo", 64'(obs_lo), 64'h0);
    check("sub_fl", 64'(obs_fl), 64'b0110);
    run_op(5'h07, 32'h1, 32'h0, 0, 0, 1'b0, 4'h0);
    check("rsc_lo", 64'(obs_lo), 64'hFFFF_FFFE);
    check("rsc_fl", 64'(obs_fl), 64'b1000);
    run_op(5'h10, 32'h7, 32'h12, 0, 0, 1'b0, 4'h0);
    check("mul1_lo", 64'(obs_lo), 64'h7E);
    check("mul1_mc", 64'(obs_mc), 64'h1);
    run_op(5'h10, 32'h7, 32'h0100_0000, 0, 0, 1'b0, 4'h0);
    check("mul4_lo", 64'(obs_lo), 64'h0700_0000);
    check("mul4_mc", 64'(obs_mc), 64'h4);
    run_op(5'h16, 32'h3, 32'hFFFF_FF80, 0, 0, 1'b0, 4'h0);
    check("smull", {32'(obs_hi), 32'(obs_lo)}, 64'hFFFF_FFFF_FFFF_FE80);
    check("smull_mc", 64'(obs_mc), 64'h1);
    check("smull_n", 64'(obs_fl[3]), 64'h1);
    run_op(5'h14, 32'h3, 32'hFFFF_FF80, 0, 0, 1'b0, 4'h3);
    check("umull", {32'(obs_hi), 32'(obs_lo)}, 64'h0000_0002_FFFF_FE80);
    check("umull_mc", 64'(obs_mc), 64'h4);
    check("umull_fl", 64'(obs_fl), 64'b0011);

    // MLA with an ADD held on the input: ADD may only enter in the MLA's out_valid cycle
    model(5'h04, 32'h1234, 32'h10, 0, 0, 1'b0, 4'h0, elo, ehi, efl, em, elat);
    @(negedge clk);
    in_valid = 1'b1; op = 5'h11; op_a = 32'd2; op_b = 32'd3; acc_lo = 32'd4; acc_hi = 32'h0;
    flags_in = 4'h0; shifter_carry = 1'b0;
    @(negedge clk);
    op = 5'h04; op_a = 32'h1234; op_b = 32'h10;
    check("bb_c1_vld", 64'(out_valid), 64'(1'b0));
    check("bb_c1_rdy", 64'(in_ready), 64'(1'b0));
    @(negedge clk);
    check("bb_c2_vld", 64'(out_valid), 64'(1'b1));
    check("bb_c2_lo", 64'(result_lo), 64'd10);
    check("bb_c2_mc", 64'(mul_cycles), 64'd1);
    check("bb_c2_rdy", 64'(in_ready), 64'(1'b1));
    @(negedge clk);
    in_valid = 1'b0;
    check("bb_c3_vld", 64'(out_valid), 64'(1'b1));
    check("bb_c3_lo", 64'(result_lo), 64'(elo));
    check("bb_c3_fl", 64'(flags_out), 64'(efl));
    check("bb_c3_mc", 64'(mul_cycles), 64'd0);
    @(negedge clk);
    check("bb_c4_vld", 64'(out_valid), 64'(1'b0));

    // Reset during the second multiply iteration
    in_valid = 1'b1; op = 5'h14; op_a = 32'h5; op_b = 32'h8000_0000;
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_vld", 64'(out_valid), 64'(1'b0));
    check("abort_rdy", 64'(in_ready), 64'(1'b1));
    check("abort_lo", 64'(result_lo), 64'h0);
    check("abort_hi", 64'(result_hi), 64'h0);
    check("abort_fl", 64'(flags_out), 64'h0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_quiet", 64'(seen), 64'(1'b0));
    run_op(5'h04, 32'h10, 32'h20, 0, 0, 1'b0, 4'h0);
    check("post_rst_add", 64'(obs_lo), 64'h30);

    // Randomized ops
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 0) o = 5'($urandom_range(0, 15));
      else                           o = mul_ops[$urandom_range(0, 5)];
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = $urandom >> (8 * $urandom_range(1, 3));
        2:       b = ~($urandom >> (8 * $urandom_range(1, 3)));
        default: b = 32'h1 << $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 7) == 0) b = 32'h0;
      run_op(o, a, b, $urandom, $urandom, 1'($urandom), 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
